// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//   Sequences one branch/non-branch instruction at a time through a three-state
//   FSM (IDLE -> EVAL -> COMMIT) and maintains the program counter.
//   IDLE accepts an instruction. EVAL resolves the branch condition, using the
//   incoming ALU flags when they arrive that cycle and the flag register
//   otherwise. COMMIT loads the new pc and pulses pc_update.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   instr_valid/ready : instruction handshake (ready only in IDLE, not stalled)
//   op_code, offset   : opcode and signed word offset of the instruction
//   rs_value          : register operand, target of br
//   flags_valid       : one-cycle strobe qualifying sign/carry/zero
//   sign, carry, zero : ALU result flags
//   stall             : freezes the FSM and every register while high
//   pc                : registered program counter
//   pc_update, taken  : commit pulse and its taken qualifier
//   link_we, link_data: link-register write strobe and return address (bl)
//   busy              : FSM is not in IDLE
// -----------------------------------------------------------------------------
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFFSET_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [5:0]          op_code,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [31:0]         rs_value,
  input  logic                flags_valid,
  input  logic                sign,
  input  logic                carry,
  input  logic                zero,
  input  logic                stall,
  output logic [31:0]         pc,
  output logic                pc_update,
  output logic                taken,
  output logic                link_we,
  output logic [31:0]         link_data,
  output logic                busy
);

  localparam logic [5:0] OP_B    = 6'b000111;
  localparam logic [5:0] OP_BL   = 6'b001000;
  localparam logic [5:0] OP_BCY  = 6'b001001;
  localparam logic [5:0] OP_BNCY = 6'b001010;
  localparam logic [5:0] OP_BLTZ = 6'b001011;
  localparam logic [5:0] OP_BZ   = 6'b001100;
  localparam logic [5:0] OP_BNZ  = 6'b001101;
  localparam logic [5:0] OP_BR   = 6'b001110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_s, r_c, r_z;
  logic [5:0]          r_op;
  logic [OFFSET_W-1:0] r_offset;
  logic [31:0]         r_rs;
  logic [31:0]         r_pc;
  logic [31:0]         r_pc_lat;
  logic [31:0]         r_next_pc;
  logic                r_taken;
  logic                r_is_bl;

  logic                w_hs;
  logic                w_s, w_c, w_z;
  logic                w_taken;
  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_off_sext;
  logic [31:0]         w_target;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) so all registers sample the
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else if (!stall)
      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and FSM-driven outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    pc_update   = 1'b0;
    unique case (r_state)
      IDLE: begin
        instr_ready = !stall && !rst;
        if (instr_valid)
          w_state_nxt = EVAL;
      end
      EVAL:   w_state_nxt = COMMIT;
      COMMIT: begin
        // rst gates the pulse so a reset in COMMIT discards the instruction.
        pc_update   = !stall && !rst;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hs      = instr_valid && instr_ready;
  assign taken     = pc_update && r_taken;
  assign link_we   = pc_update && r_is_bl;
  assign link_data = link_we ? r_pc_lat + 32'd4 : 32'd0;
  assign busy      = (r_state != IDLE);
  assign pc        = r_pc;

  // ---------------------------------------------------------------------------
  // Branch decision (evaluated while in EVAL)
  // ---------------------------------------------------------------------------
  // Fresh flags arriving in the EVAL cycle take precedence over the register.
  assign w_s = flags_valid ? sign  : r_s;
  assign w_c = flags_valid ? carry : r_c;
  assign w_z = flags_valid ? zero  : r_z;

  always_comb begin
    w_taken = 1'b0;
    unique case (r_op)
      OP_BLTZ:            w_taken = w_s && !w_z;
      OP_BZ:              w_taken = !w_s && w_z;
      OP_BNZ:             w_taken = !w_z;
      OP_BNCY:            w_taken = !w_c;
      OP_BCY:             w_taken = w_c;
      OP_B, OP_BL, OP_BR: w_taken = 1'b1;
      default:            w_taken = 1'b0;
    endcase
  end

  assign w_pc_plus4 = r_pc_lat + 32'd4;
  assign w_off_sext = {{(32-OFFSET_W){r_offset[OFFSET_W-1]}}, r_offset};
  assign w_target   = !w_taken      ? w_pc_plus4 :
                      (r_op == OP_BR) ? r_rs :
                                        w_pc_plus4 + (w_off_sext << 2);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the latched instruction fields are reset too; they are few and a
  // known value keeps the decision logic free of X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_s       <= 1'b0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_op      <= '0;
      r_offset  <= '0;
      r_rs      <= '0;
      r_pc_lat  <= '0;
      r_next_pc <= '0;
      r_taken   <= 1'b0;
      r_is_bl   <= 1'b0;
    end else if (!stall) begin
      if (flags_valid) begin
        r_s <= sign;
        r_c <= carry;
        r_z <= zero;
      end
      if (w_hs) begin
        r_op     <= op_code;
        r_offset <= offset;
        r_rs     <= rs_value;
        r_pc_lat <= r_pc;
      end
      if (r_state == EVAL) begin
        r_taken   <= w_taken;
        r_next_pc <= w_target;
        r_is_bl   <= (r_op == OP_BL);
      end
      if (r_state == COMMIT)
        r_pc <= r_next_pc;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_sequencer
//   Directed bench for branch_sequencer. A cycle-level behavioural model tracks
//   the architectural pc, the flag register and the one in-flight instruction;
//   a negedge compare process checks every output against it each cycle.
//   Literal expectations after each directed instruction pin the model.
// -----------------------------------------------------------------------------
module tb_branch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [5:0] B    = 6'h07;
  localparam logic [5:0] BL   = 6'h08;
  localparam logic [5:0] BCY  = 6'h09;
  localparam logic [5:0] BNCY = 6'h0A;
  localparam logic [5:0] BLTZ = 6'h0B;
  localparam logic [5:0] BZ   = 6'h0C;
  localparam logic [5:0] BNZ  = 6'h0D;
  localparam logic [5:0] BR   = 6'h0E;
  localparam logic [5:0] NOP  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  op_code;
  logic [15:0] offset;
  logic [31:0] rs_value;
  logic        flags_valid;
  logic        sign, carry, zero;
  logic        stall;
  logic [31:0] pc;
  logic        pc_update;
  logic        taken;
  logic        link_we;
  logic [31:0] link_data;
  logic        busy;

  branch_sequencer #(.RESET_PC(RESET_PC), .OFFSET_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op_code     (op_code),
    .offset      (offset),
    .rs_value    (rs_value),
    .flags_valid (flags_valid),
    .sign        (sign),
    .carry       (carry),
    .zero        (zero),
    .stall       (stall),
    .pc          (pc),
    .pc_update   (pc_update),
    .taken       (taken),
    .link_we     (link_we),
    .link_data   (link_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic void outcome(input logic [5:0] op, input logic [15:0] off,
                                  input logic [31:0] rs, input logic [31:0] at_pc,
                                  input bit s, input bit c, input bit z,
                                  output bit tk, output logic [31:0] nxt);
    int soff;
    soff = int'($signed(off));
    case (op)
      B, BL, BR: tk = 1;
      BCY:       tk = c;
      BNCY:      tk = !c;
      BLTZ:      tk = s && !z;
      BZ:        tk = !s && z;
      BNZ:       tk = !z;
      default:   tk = 0;
    endcase
    if (!tk)          nxt = at_pc + 32'd4;
    else if (op == BR) nxt = rs;
    else              nxt = 32'(longint'(at_pc) + 4 + longint'(soff) * 4);
  endfunction

  bit          m_init = 0;
  logic [31:0] m_pc;
  bit          m_s, m_c, m_z;
  bit          m_inflight;
  int          m_steps_left;   // edges still needed before the pc moves
  logic [5:0]  m_op;
  logic [15:0] m_off;
  logic [31:0] m_rs, m_pclat, m_next;
  bit          m_taken;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_pc = RESET_PC; m_s = 0; m_c = 0; m_z = 0; m_inflight = 0;
    end else if (!stall) begin
      if (m_inflight && m_steps_left == 2) begin
        outcome(m_op, m_off, m_rs, m_pclat,
                flags_valid ? sign : m_s, flags_valid ? carry : m_c,
                flags_valid ? zero : m_z, m_taken, m_next);
        m_steps_left = 1;
      end else if (m_inflight && m_steps_left == 1) begin
        m_pc = m_next;
        m_inflight = 0;
      end else if (!m_inflight && instr_valid) begin
        m_op = op_code; m_off = offset; m_rs = rs_value; m_pclat = m_pc;
        m_inflight = 1; m_steps_left = 2;
      end
      if (flags_valid) begin
        m_s = sign; m_c = carry; m_z = zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and event monitor (negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          n_upd = 0;
  int          n_link = 0;
  int          last_upd_cyc = 0;
  logic        last_taken;
  logic [31:0] last_ld;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit e_upd, e_bl;
    if (m_init) begin
      e_upd = !rst && m_inflight && m_steps_left == 1 && !stall;
      e_bl  = e_upd && (m_op == BL);
      check("pc",          pc,          m_pc);
      check("busy",        busy,        m_inflight);
      check("instr_ready", instr_ready, !rst && !m_inflight && !stall);
      check("pc_update",   pc_update,   e_upd);
      check("taken",       taken,       e_upd && m_taken);
      check("link_we",     link_we,     e_bl);
      if (e_bl) check("link_data", link_data, m_pclat + 32'd4);
    end
    if (pc_update === 1'b1) begin
      n_upd++;
      last_upd_cyc = cyc;
      last_taken   = taken;
      last_ld      = link_data;
    end
    if (link_we === 1'b1) n_link++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input bit s, input bit c, input bit z);
    flags_valid = 1; sign = s; carry = c; zero = z;
    tick();
    flags_valid = 0;
  endtask

  int hs_cyc;

  // Issues one instruction from IDLE; optionally presents fresh flags in the
  // EVAL cycle and stalls for stall_n cycles in COMMIT. Returns once the new pc
  // is visible.
  task automatic issue(input logic [5:0] op, input logic [15:0] off, input logic [31:0] rs,
                       input bit fv, input bit fs, input bit fc, input bit fz,
                       input int stall_n);
    check("idle_before_issue", instr_ready, 1'b1);
    instr_valid = 1; op_code = op; offset = off; rs_value = rs;
    hs_cyc = cyc;
    tick();
    instr_valid = 0;
    flags_valid = fv; sign = fs; carry = fc; zero = fz;
    tick();
    flags_valid = 0;
    stall = (stall_n > 0);
    repeat (stall_n) tick();
    stall = 0;
    tick();
  endtask

  int upd0, link0;

  initial begin
    rst = 1; instr_valid = 1; op_code = B; offset = 16'd1; rs_value = '0;
    flags_valid = 1; sign = 1; carry = 1; zero = 1; stall = 1;
    tick();
    check("reset_ready_low", instr_ready, 1'b0);
    tick();
    rst = 0; stall = 0; flags_valid = 0; instr_valid = 0; sign = 0; carry = 0; zero = 0;
    #1;
    check("reset_pc",    pc,          RESET_PC);
    check("reset_busy",  busy,        1'b0);
    check("ready_after_reset", instr_ready, 1'b1);

    // b +3 at pc 0 -> 0x10, pulse two cycles after handshake
    upd0 = n_upd;
    issue(B, 16'd3, 32'd0, 0, 0, 0, 0, 0);
    check("b_pc",      pc,                     32'h10);
    check("b_taken",   last_taken,             1'b1);
    check("b_latency", last_upd_cyc - hs_cyc,  2);
    check("b_pulses",  n_upd - upd0,           1);

    // Z=1, S=0 registered; bz -1 -> 0x10; bnz -> not taken, 0x14
    set_flags(0, 0, 1);
    issue(BZ, 16'hFFFF, 32'd0, 0, 0, 0, 0, 0);
    check("bz_pc",     pc,         32'h10);
    check("bz_taken",  last_taken, 1'b1);
    issue(BNZ, 16'd5, 32'd0, 0, 0, 0, 0, 0);
    check("bnz_pc",    pc,         32'h14);
    check("bnz_taken", last_taken, 1'b0);

    // Reach 0x20, then bl +2 and br
    issue(B, 16'd2, 32'd0, 0, 0, 0, 0, 0);
    check("b2_pc", pc, 32'h20);
    link0 = n_link;
    issue(BL, 16'd2, 32'd0, 0, 0, 0, 0, 0);
    check("bl_pc",       pc,              32'h2C);
    check("bl_link_cnt", n_link - link0,  1);
    check("bl_link_data", last_ld,        32'h24);
    issue(BR, 16'd0, 32'h100, 0, 0, 0, 0, 0);
    check("br_pc",       pc,              32'h100);
    check("br_no_link",  n_link - link0,  1);

    // bcy with stale C=0 and carry bypassed in EVAL -> taken
    issue(BCY, 16'd1, 32'd0, 1, 0, 1, 0, 0);
    check("bcy_bypass_taken", last_taken, 1'b1);
    check("bcy_pc",           pc,         32'h108);
    upd0 = n_upd;
    issue(BCY, 16'd1, 32'd0, 1, 0, 1, 0, 2);
    check("bcy_stall_pc",      pc,                    32'h110);
    check("bcy_stall_latency", last_upd_cyc - hs_cyc, 4);
    check("bcy_stall_pulses",  n_upd - upd0,          1);

    // C=1 registered -> bncy not taken; bltz with S=1, Z=0 -> taken
    issue(BNCY, 16'd7, 32'd0, 0, 0, 0, 0, 0);
    check("bncy_pc", pc, 32'h114);
    set_flags(1, 0, 0);
    issue(BLTZ, 16'hFFFE, 32'd0, 0, 0, 0, 0, 0);
    check("bltz_pc", pc, 32'h110);

    // Wrap-around on a non-branch opcode
    issue(BR, 16'd0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    issue(NOP, 16'd9, 32'd0, 0, 0, 0, 0, 0);
    check("wrap_pc",    pc,         32'h0);
    check("wrap_taken", last_taken, 1'b0);

    // Reset in EVAL discards a b
    issue(BR, 16'd0, 32'h40, 0, 0, 0, 0, 0);
    upd0 = n_upd; link0 = n_link;
    instr_valid = 1; op_code = B; offset = 16'd4;
    tick();
    instr_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();
    check("rst_eval_pc",   pc,            RESET_PC);
    check("rst_eval_upd",  n_upd - upd0,  0);

    // Reset in COMMIT discards a bl (no pulse, no link write)
    issue(BR, 16'd0, 32'h80, 0, 0, 0, 0, 0);
    upd0 = n_upd; link0 = n_link;
    instr_valid = 1; op_code = BL; offset = 16'd4;
    tick();
    instr_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    check("rst_commit_pc",   pc,             RESET_PC);
    check("rst_commit_upd",  n_upd - upd0,   0);
    check("rst_commit_link", n_link - link0, 0);
    check("rst_commit_busy", busy,           1'b0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: OFFSET_W, default 16, width of the signed word offset field.
REQ-003 Ports: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Ports: rst  input  1  synchronous reset, active-high.
REQ-005 Ports: instr_valid  input  1  an instruction is presented for sequencing.
REQ-006 Ports: instr_ready  output  1  block accepts an instruction this cycle.
REQ-007 Ports: op_code  input  6  opcode of the presented instruction.
REQ-008 Ports: offset  input  OFFSET_W  signed word offset for PC-relative branches.
REQ-009 Ports: rs_value  input  32  register operand, used as the target by br.
REQ-010 Ports: flags_valid  input  1  one-cycle pulse: sign/carry/zero hold fresh ALU flags.
REQ-011 Ports: sign, carry, zero  input  1 each  ALU result flags.
REQ-012 Ports: stall  input  1  freezes the FSM and all registers while high.
REQ-013 Ports: pc  output  32  current program counter, registered.
REQ-014 Ports: pc_update  output  1  one-cycle pulse in the cycle pc is loaded.
REQ-015 Ports: taken  output  1  qualifies pc_update: the branch was taken.
REQ-016 Ports: link_we, link_data  output  1, 32  link-register write strobe and return address.
REQ-017 Ports: busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, EVAL and COMMIT, moving IDLE->EVAL->COMMIT->IDLE, and SHALL hold its state during any cycle with stall=1.
REQ-019 instr_ready SHALL be 1 only in IDLE with stall=0; the handshake is instr_valid & instr_ready, and on handshake the block latches op_code, offset, rs_value and pc.
REQ-020 The flag register (S,C,Z) SHALL load sign/carry/zero on any cycle with flags_valid=1 and stall=0, in any state.
REQ-021 In EVAL, if flags_valid=1 in that cycle, the incoming flags SHALL be used for the decision (bypass); otherwise the registered flags are used.
REQ-022 Taken conditions, decided in EVAL:
  - 001011 bltz: S & !Z
  - 001100 bz: !S & Z
  - 001101 bnz: !Z
  - 001010 bncy: !C
  - 001001 bcy: C
  - 000111 b, 001000 bl, 001110 br: always taken
  - any other opcode: not taken
REQ-023 Target selection:
  - br: latched rs_value
  - other taken branches: pc_lat + 4 + (sign-extended offset << 2)
  - not taken: pc_lat + 4
  All arithmetic is 32-bit modulo 2^32 (wrap-around, no overflow flag).
REQ-024 In COMMIT with stall=0, the block SHALL load pc with the EVAL-computed next PC and pulse pc_update=1 for one cycle; taken equals the EVAL decision during that cycle and is 0 otherwise.
REQ-025 For bl only, link_we SHALL pulse with pc_update, and link_data = pc_lat + 4; link_we is 0 for all other opcodes, including not-taken conditionals.
REQ-026 Latency: handshake in cycle N gives pc_update in cycle N+2 (plus stall cycles), and the new pc is visible from cycle N+3; sustained throughput is one instruction per 3 cycles.
REQ-027 pc, flag register, FSM state and latched fields SHALL change only as stated above; pc_update, taken and link_we are 0 outside COMMIT.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, flags S=C=Z=0, pc_update=taken=link_we=0, link_data=0 and busy=0.
REQ-029 rst SHALL override stall and flags_valid.
REQ-030 A reset during EVAL or COMMIT SHALL discard the in-flight instruction with no pc_update and no link_we.
REQ-031 instr_ready SHALL be 0 in the reset cycle and 1 in the first cycle after reset if stall=0.

Verification
REQ-032 Reset, then b with offset=3 at pc=0 -> pc_update=1 and taken=1 two cycles after handshake; pc=0x10 afterwards.
REQ-033 flags_valid with zero=1, sign=0, then bz offset=-1 at pc=0x10 -> pc=0x10 (0x10+4-4); then bnz -> taken=0, pc=0x14.
REQ-034 bl offset=2 at pc=0x20 -> link_we=1, link_data=0x24, pc=0x2C; then br with rs_value=0x100 -> pc=0x100, link_we=0.
REQ-035 bcy issued with stale C=0 and flags_valid+carry=1 in the EVAL cycle -> taken=1 (bypass); repeat with stall=1 for 2 cycles in COMMIT -> pc_update delayed 2 cycles, and pulses once.
REQ-036 pc=0xFFFFFFFC with a non-branch opcode -> pc wraps to 0x00000000; rst asserted in EVAL of a following b -> no pc_update, pc=RESET_PC.
